// File: rtl/bcd_disp_pkg.sv
// Shared types and helpers for the BCD counter / digit-scan display path.
package bcd_disp_pkg;

  typedef logic [3:0] bcd_t;

  // The downstream segment decoder turns every segment off for this code.
  localparam bcd_t BLANK_CODE = 4'hF;

  function automatic bcd_t bcd_sat(input bcd_t nibble);
    return (nibble > 4'd9) ? 4'd9 : nibble;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Count controls in, BCD count and scanned digit bus out.
interface bcd_scan_counter_if
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                    clear;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic                    cnt_en;
  logic                    tick;
  logic                    up;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    carry;
  bcd_t                    D;
  logic [NUM_DIGITS-1:0]   dig_sel;

  modport master (
    output clear, load, load_val, cnt_en, tick, up,
    input  count, carry, D, dig_sel
  );

  modport slave (
    input  clear, load, load_val, cnt_en, tick, up,
    output count, carry, D, dig_sel
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit with clear/load and ripple increment/decrement.
module bcd_digit_counter
  import bcd_disp_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  bcd_t load_digit,
  input  logic inc,
  input  logic dec,
  output bcd_t q,
  output logic wrap_out
);

  // Wrap is combinational so the next digit moves on the same edge.
  assign wrap_out = (inc && (q == 4'd9)) || (dec && (q == 4'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= bcd_sat(load_digit);
    end else if (inc) begin
      q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
    end else if (dec) begin
      q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter driving a time-multiplexed single-digit bus
// with one-hot digit select and optional leading-zero blanking.
module bcd_scan_counter
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic               clk,
  input  logic               rst,
  bcd_scan_counter_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic                  step;
  logic [NUM_DIGITS:0]   inc_c;
  logic [NUM_DIGITS:0]   dec_c;
  logic [NUM_DIGITS-1:0] wrap;
  bcd_t                  q [NUM_DIGITS];
  logic                  carry_nxt;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         scan_idx;
  logic [NUM_DIGITS-1:0] blank;
  logic                  zero_above;

  bcd_t                  d_p1;
  logic [NUM_DIGITS-1:0] sel_p1;
  logic                  carry_p1;

  // clear and load outrank the tick, so the ripple chain only starts on a plain tick.
  assign step     = bus.tick & bus.cnt_en & ~bus.clear & ~bus.load;
  assign inc_c[0] = step & bus.up;
  assign dec_c[0] = step & ~bus.up;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_counter u_digit (
      .clk        (clk),
      .rst        (rst),
      .clear      (bus.clear),
      .load       (bus.load),
      .load_digit (bus.load_val[4*i +: 4]),
      .inc        (inc_c[i]),
      .dec        (dec_c[i]),
      .q          (q[i]),
      .wrap_out   (wrap[i])
    );
    assign inc_c[i+1]          = inc_c[i] & wrap[i];
    assign dec_c[i+1]          = dec_c[i] & wrap[i];
    assign bus.count[4*i +: 4] = q[i];
  end

  assign carry_nxt = inc_c[NUM_DIGITS] | dec_c[NUM_DIGITS];

  // A digit above 0 blanks when it and every higher digit read zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (q[i] == 4'd0);
      blank[i]   = (BLANK_LEADING != 0) && zero_above;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      scan_idx <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      presc    <= presc + 1'b1;
    end
  end

  // ---- stage p1: D, dig_sel and carry registered together ----
  always_ff @(posedge clk) begin
    if (rst) begin
      d_p1     <= 4'h0;
      sel_p1   <= NUM_DIGITS'(1);
      carry_p1 <= 1'b0;
    end else begin
      d_p1     <= blank[scan_idx] ? BLANK_CODE : q[scan_idx];
      sel_p1   <= NUM_DIGITS'(1) << scan_idx;
      carry_p1 <= carry_nxt;
    end
  end

  assign bus.D       = d_p1;
  assign bus.dig_sel = sel_p1;
  assign bus.carry   = carry_p1;

endmodule
